systolic_skew_feeder: RTL and testbench

- Edge feeder directly upstream of one edge (row or column) of the systolic processing-unit array.
- Accepts one operand vector per beat: SIZE elements, one per array lane.
- Re-times the vector into diagonal (skewed) order, so lane i is delayed i cycles relative to lane 0 and wavefronts meet correctly inside the array.
- Two instances (A edge, B edge) run in lockstep under a common controller. A per-job FSM counts the K dimension and drains the skew before signalling done.

---
 rtl/systolic_skew_feeder_pkg.sv | 21 ++
 rtl/systolic_skew_feeder_delay_line.sv | 37 +++
 rtl/systolic_skew_feeder.sv | 142 ++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_skew_feeder_pkg.sv
// Shared defaults, feeder state encoding and the lane-slicing helper
// used by the systolic skew feeder and its delay lines.
package systolic_pkg;

    localparam int SIZE_DEFAULT   = 32;
    localparam int DATA_W_DEFAULT = 32;
    localparam int K_W_DEFAULT    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feeder_state_t;

    // Bit offset of lane 'lane' inside a flat vector of 'width'-bit elements.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_delay_line.sv
// Fixed-depth registered delay for one array lane: data word plus a valid bit,
// shifting every cycle with no stall, cleared by the asynchronous reset.
module skew_delay_line #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              vin,
    output logic [DATA_W-1:0] dout,
    output logic              vout
);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                data_q[s] <= '0;
            end
            valid_q <= '0;
        end else begin
            data_q[0]  <= din;
            valid_q[0] <= vin;
            for (int s = 1; s < DEPTH; s++) begin
                data_q[s]  <= data_q[s-1];
                valid_q[s] <= valid_q[s-1];
            end
        end
    end

    assign dout = data_q[DEPTH-1];
    assign vout = valid_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skews one operand vector per beat into diagonal order for a systolic array edge.
// Build option: define SKEW_ACC_CLR_EN to add the per-lane acc_clr output.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int SIZE   = SIZE_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int K_W    = K_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [K_W-1:0]         k_len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SIZE*DATA_W-1:0] in_data,
    output logic [SIZE*DATA_W-1:0] skew_out,
    output logic [SIZE-1:0]        skew_valid,
    output logic                   busy,
`ifdef SKEW_ACC_CLR_EN
    output logic [SIZE-1:0]        acc_clr,
`endif
    output logic                   done
);

    localparam int DRAIN_W = $clog2(SIZE + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(SIZE - 1);
`ifdef SKEW_ACC_CLR_EN
    localparam int LINE_W = DATA_W + 1;
`else
    localparam int LINE_W = DATA_W;
`endif

    feeder_state_t      state, state_next;
    logic [K_W-1:0]     k_q;
    logic [K_W-1:0]     beat_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               accept;
    logic               last_beat;

    assign accept    = in_valid && in_ready;
    assign last_beat = accept && ((beat_cnt + K_W'(1)) == k_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k_q       <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                k_q      <= k_len;
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + K_W'(1);
            end
            if (state == DRAIN) begin
                drain_cnt <= drain_cnt + DRAIN_W'(1);
            end else begin
                drain_cnt <= '0;
            end
        end
    end

    // DRAIN holds for SIZE cycles so the last beat clears the deepest lane before done.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (k_len == '0) ? DONE : FEED;
                end
            end
            FEED: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (last_beat) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == DRAIN_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef SKEW_ACC_CLR_EN
    logic first_q;

    // Marks that the next accepted beat is the first of the job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q <= 1'b0;
        end else if (state == IDLE && start && k_len != '0) begin
            first_q <= 1'b1;
        end else if (accept) begin
            first_q <= 1'b0;
        end
    end
`endif

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        logic [DATA_W-1:0] lane_data;
        logic [LINE_W-1:0] line_in;
        logic [LINE_W-1:0] line_out;

        assign lane_data = accept ? in_data[lane_lsb(i, DATA_W) +: DATA_W] : '0;
`ifdef SKEW_ACC_CLR_EN
        assign line_in    = {accept && first_q, lane_data};
        assign acc_clr[i] = line_out[DATA_W];
`else
        assign line_in = lane_data;
`endif

        skew_delay_line #(
            .DEPTH (i + 1),
            .DATA_W(LINE_W)
        ) u_line (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (line_in),
            .vin  (accept),
            .dout (line_out),
            .vout (skew_valid[i])
        );

        assign skew_out[lane_lsb(i, DATA_W) +: DATA_W] = line_out[DATA_W-1:0];
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed self-checking bench for systolic_skew_feeder at SIZE=4, DATA_W=8.
// The acc_clr checks are compiled only when SKEW_ACC_CLR_EN is defined.
module tb_systolic_skew_feeder;

    localparam int SIZE   = 4;
    localparam int DATA_W = 8;
    localparam int K_W    = 16;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic [K_W-1:0]         k_len = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [SIZE*DATA_W-1:0] in_data = '0;
    logic [SIZE*DATA_W-1:0] skew_out;
    logic [SIZE-1:0]        skew_valid;
    logic                   busy;
    logic                   done;
`ifdef SKEW_ACC_CLR_EN
    logic [SIZE-1:0]        acc_clr;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    systolic_skew_feeder #(
        .SIZE  (SIZE),
        .DATA_W(DATA_W),
        .K_W   (K_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .k_len     (k_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .skew_out  (skew_out),
        .skew_valid(skew_valid),
        .busy      (busy),
`ifdef SKEW_ACC_CLR_EN
        .acc_clr   (acc_clr),
`endif
        .done      (done)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [K_W-1:0] kl, input logic v,
                                 input logic [SIZE*DATA_W-1:0] d);
        start    = st;
        k_len    = kl;
        in_valid = v;
        in_data  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] vec(input logic [7:0] l0, input logic [7:0] l1,
                                        input logic [7:0] l2, input logic [7:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [7:0] lane(input int i);
        return skew_out[i*DATA_W +: DATA_W];
    endfunction

    initial begin
        $display("[TB] reset and idle");
        applyStimulus(1'b0, '0, 1'b0, '0);
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checkOutput($sformatf("idle_c%0d", c), {skew_out, skew_valid, in_ready, busy, done}, 64'd0);
        end

        $display("[TB] basic skew, k_len=2");
        applyStimulus(1'b1, 16'd2, 1'b0, '0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, vec(1, 2, 3, 4));
        checkOutput("basic_ready", in_ready, 1);
        checkOutput("basic_busy", busy, 1);
        tick();
        checkOutput("basic_l0_b1", lane(0), 1);
        applyStimulus(1'b0, '0, 1'b1, vec(5, 6, 7, 8));
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("basic_l0_b2", lane(0), 5);
        checkOutput("basic_l1_b1", lane(1), 2);
        checkOutput("basic_drain_ready", in_ready, 0);
        tick();
        tick();
        checkOutput("basic_l3_b1", lane(3), 4);
        checkOutput("basic_valid_p5", skew_valid, 4'b1100);
        checkOutput("basic_done_p5", done, 0);
        tick();
        checkOutput("basic_l3_b2", lane(3), 8);
        checkOutput("basic_valid_p6", skew_valid, 4'b1000);
        checkOutput("basic_done_p6", done, 0);
        checkOutput("basic_busy_p6", busy, 1);
        tick();
        checkOutput("basic_done_p7", done, 1);
        checkOutput("basic_valid_p7", skew_valid, 4'b0000);
        checkOutput("basic_busy_p7", busy, 0);
        tick();
        checkOutput("basic_done_p8", done, 0);

        $display("[TB] bubble between beats");
        applyStimulus(1'b1, 16'd2, 1'b0, '0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, vec(1, 2, 3, 4));
        tick();
        checkOutput("bub_l0_b1", lane(0), 1);
        checkOutput("bub_ready_gap", in_ready, 1);
        applyStimulus(1'b0, '0, 1'b0, vec(8'hff, 8'hff, 8'hff, 8'hff));
        tick();
        checkOutput("bub_l0_gap", lane(0), 0);
        checkOutput("bub_l1_b1", lane(1), 2);
        checkOutput("bub_valid_p3", skew_valid, 4'b0010);
        applyStimulus(1'b0, '0, 1'b1, vec(5, 6, 7, 8));
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("bub_ready_stop", in_ready, 0);
        checkOutput("bub_l0_b2", lane(0), 5);
        checkOutput("bub_l1_gap", lane(1), 0);
        checkOutput("bub_l2_b1", lane(2), 3);
        checkOutput("bub_valid_p4", skew_valid, 4'b0101);
        tick();
        tick();
        checkOutput("bub_l3_gap", lane(3), 0);
        checkOutput("bub_l2_b2", lane(2), 7);
        checkOutput("bub_valid_p6", skew_valid, 4'b0100);
        tick();
        checkOutput("bub_l3_b2", lane(3), 8);
        checkOutput("bub_valid_p7", skew_valid, 4'b1000);
        checkOutput("bub_done_p7", done, 0);
        tick();
        checkOutput("bub_done_p8", done, 1);
        tick();
        checkOutput("bub_done_p9", done, 0);
        checkOutput("bub_busy_p9", busy, 0);

        $display("[TB] zero-length job");
        applyStimulus(1'b1, 16'd0, 1'b0, '0);
        checkOutput("zero_busy_p0", busy, 0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("zero_done_p1", done, 1);
        checkOutput("zero_busy_p1", busy, 0);
        checkOutput("zero_valid_p1", skew_valid, 4'b0000);
        tick();
        checkOutput("zero_done_p2", done, 0);
        checkOutput("zero_busy_p2", busy, 0);

        $display("[TB] abort by reset mid-feed");
        applyStimulus(1'b1, 16'd3, 1'b0, '0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, vec(9, 10, 11, 12));
        tick();
        checkOutput("abort_l0_b1", lane(0), 9);
        checkOutput("abort_busy", busy, 1);
        applyStimulus(1'b0, '0, 1'b1, vec(13, 14, 15, 16));
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_outputs", {skew_out, skew_valid, in_ready, busy, done}, 64'd0);
        applyStimulus(1'b0, '0, 1'b0, '0);
        tick();
        checkOutput("abort_done_r1", done, 0);
        tick();
        checkOutput("abort_done_r2", done, 0);
        rst_n = 1'b1;
        tick();
        checkOutput("abort_idle", {busy, done}, 0);

        $display("[TB] job after abort, start ignored while busy");
        applyStimulus(1'b1, 16'd1, 1'b0, '0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, vec(21, 22, 23, 24));
        tick();
        applyStimulus(1'b1, 16'd5, 1'b0, '0);
        checkOutput("post_l0", lane(0), 21);
        checkOutput("post_busy", busy, 1);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0);
        tick();
        tick();
        checkOutput("post_l3", lane(3), 24);
        checkOutput("post_done_p5", done, 0);
        tick();
        checkOutput("post_done_p6", done, 1);
        tick();
        checkOutput("post_done_p7", done, 0);
        checkOutput("post_busy_p7", busy, 0);
        tick();
        checkOutput("post_busy_p8", busy, 0);

`ifdef SKEW_ACC_CLR_EN
        $display("[TB] accumulator clear, k_len=3");
        applyStimulus(1'b1, 16'd3, 1'b0, '0);
        tick();
        for (int p = 1; p <= 9; p++) begin
            checkOutput($sformatf("clr_p%0d", p), acc_clr,
                        (p >= 2 && p <= 5) ? 4'(1 << (p - 2)) : 4'd0);
            checkOutput($sformatf("clr_done_p%0d", p), done, (p == 8) ? 1 : 0);
            applyStimulus(p == 2, 16'd1, p <= 3, vec(8'(p), 8'(p), 8'(p), 8'(p)));
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("clr_busy_after", busy, 0);
        checkOutput("clr_done_after", done, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
